// File: rtl/pc_sequencer_if.sv
// Bundle of control inputs and fetch-side outputs for pc_sequencer.
// The sequencer sits on the slave modport. The driver of the controls sits on the master modport.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              call;
    logic              ret;
    logic              iret;
    logic              int_req;
    logic              vec_valid;
    logic [ADDR_W-1:0] vec_data;
    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              in_int;
    logic [ADDR_W-1:0] epc;
    logic              ras_empty;
    logic              ras_full;
    logic              ret_err;
    logic              state_dbg;

    modport master (
        output stall, br_taken, br_target, call, ret, iret, int_req, vec_valid, vec_data,
        input  pc, fetch_en, in_int, epc, ras_empty, ras_full, ret_err, state_dbg
    );

    modport slave (
        input  stall, br_taken, br_target, call, ret, iret, int_req, vec_valid, vec_data,
        output pc, fetch_en, in_int, epc, ras_empty, ras_full, ret_err, state_dbg
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-address generator with return-address stack, interrupt entry through a vector slot, and EPC/iret.
// state_dbg mirrors the FSM state register (0 = RUN, 1 = INT_WAIT).
module pc_sequencer #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = 'h20,
    parameter logic [ADDR_W-1:0] INT_VEC_PTR = 'h0,
    parameter int                INC         = 1,
    parameter int                RAS_DEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    typedef enum logic {
        RUN      = 1'b0,
        INT_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ret_err_q, ret_err_d;
    logic              push;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full_w;

    assign pc_inc     = pc_q + INC_V;
    assign ras_top    = ras_mem[wp_q - PTR_W'(1)];
    assign ras_full_w = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        wp_d      = wp_q;
        cnt_d     = cnt_q;
        ret_err_d = 1'b0;
        push      = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.int_req) begin
                    epc_d   = pc_q;
                    pc_d    = INT_VEC_PTR;
                    state_d = INT_WAIT;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.iret) begin
                    pc_d = epc_q;
                end else if (bus.ret) begin
                    if (cnt_q != '0) begin
                        pc_d  = ras_top;
                        wp_d  = wp_q - PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        pc_d      = pc_inc;
                        ret_err_d = 1'b1;
                    end
                end else if (bus.br_taken) begin
                    pc_d = bus.br_target;
                end else if (bus.call) begin
                    // When full, wp already points at the oldest entry, so the push overwrites it.
                    push  = 1'b1;
                    pc_d  = bus.br_target;
                    wp_d  = wp_q + PTR_W'(1);
                    cnt_d = ras_full_w ? cnt_q : cnt_q + CNT_W'(1);
                end else begin
                    pc_d = pc_inc;
                end
            end
            INT_WAIT: begin
                // vec_valid is a one-sided strobe: no ready, the sequencer always accepts it here.
                if (bus.vec_valid) begin
                    pc_d    = bus.vec_data;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_VEC;
            epc_q     <= '0;
            wp_q      <= '0;
            cnt_q     <= '0;
            ret_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
            ret_err_q <= ret_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            ras_mem[wp_q] <= pc_inc;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.epc       = epc_q;
    assign bus.fetch_en  = (state_q == RUN);
    assign bus.in_int    = (state_q == INT_WAIT);
    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_full  = ras_full_w;
    assign bus.ret_err   = ret_err_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: the driver pushes hand-computed expectations, and a monitor checks each cycle.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [7:0] C_NONE = 8'h00, C_RST = 8'h80, C_STALL = 8'h40, C_BR = 8'h20,
                           C_CALL = 8'h10, C_RET = 8'h08, C_IRET = 8'h04, C_IRQ = 8'h02,
                           C_VV = 8'h01;
    localparam logic [4:0] FE = 5'b10000, II = 5'b01000, RE = 5'b00100, RF = 5'b00010,
                           RERR = 5'b00001;

    logic [68:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    logic [68:0] mon_exp;
    logic [68:0] mon_act;
    string       mon_tag;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {bus.pc, bus.epc, bus.fetch_en, bus.in_int, bus.ras_empty, bus.ras_full,
                       bus.ret_err};
            n_checks++;
            if (mon_act === mon_exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got pc=%h epc=%h fe/ii/re/rf/rerr=%b, want pc=%h epc=%h fe/ii/re/rf/rerr=%b",
                         mon_tag, mon_act[68:37], mon_act[36:5], mon_act[4:0],
                         mon_exp[68:37], mon_exp[36:5], mon_exp[4:0]);
            end
        end
    end

    task automatic step(input string tag, input logic [7:0] ctl, input logic [31:0] tgt,
                        input logic [31:0] vd, input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic [4:0] e_fl);
        @(negedge clk);
        reset         = ctl[7];
        bus.stall     = ctl[6];
        bus.br_taken  = ctl[5];
        bus.call      = ctl[4];
        bus.ret       = ctl[3];
        bus.iret      = ctl[2];
        bus.int_req   = ctl[1];
        bus.vec_valid = ctl[0];
        bus.br_target = tgt;
        bus.vec_data  = vd;
        exp_q.push_back({e_pc, e_epc, e_fl});
        tag_q.push_back(tag);
    endtask

    initial begin
        bus.stall = 0; bus.br_taken = 0; bus.call = 0; bus.ret = 0; bus.iret = 0;
        bus.int_req = 0; bus.vec_valid = 0; bus.br_target = '0; bus.vec_data = '0;

        // T1: reset then sequential fetch
        step("t1_rst0", C_RST,  0, 0, 'h20, 0, FE | RE);
        step("t1_rst1", C_RST,  0, 0, 'h20, 0, FE | RE);
        step("t1_run0", C_NONE, 0, 0, 'h21, 0, FE | RE);
        step("t1_run1", C_NONE, 0, 0, 'h22, 0, FE | RE);
        step("t1_run2", C_NONE, 0, 0, 'h23, 0, FE | RE);
        step("t1_run3", C_NONE, 0, 0, 'h24, 0, FE | RE);
        // T2: stall then branch
        step("t2_stall0", C_STALL, 0,    0, 'h24, 0, FE | RE);
        step("t2_stall1", C_STALL, 0,    0, 'h24, 0, FE | RE);
        step("t2_br",     C_BR,    'h80, 0, 'h80, 0, FE | RE);
        step("t2_run",    C_NONE,  0,    0, 'h81, 0, FE | RE);
        // T3: call / ret
        step("t3_br",   C_BR,   'h30,  0, 'h30,  0, FE | RE);
        step("t3_call", C_CALL, 'h100, 0, 'h100, 0, FE);
        step("t3_run0", C_NONE, 0,     0, 'h101, 0, FE);
        step("t3_run1", C_NONE, 0,     0, 'h102, 0, FE);
        step("t3_ret",  C_RET,  0,     0, 'h31,  0, FE | RE);
        // T4: RAS overflow drops the oldest, underflow pulses ret_err
        step("t4_br",    C_BR,   'h50, 0, 'h50, 0, FE | RE);
        step("t4_call1", C_CALL, 'h60, 0, 'h60, 0, FE);
        step("t4_call2", C_CALL, 'h70, 0, 'h70, 0, FE);
        step("t4_call3", C_CALL, 'h80, 0, 'h80, 0, FE);
        step("t4_call4", C_CALL, 'h90, 0, 'h90, 0, FE | RF);
        step("t4_call5", C_CALL, 'hA0, 0, 'hA0, 0, FE | RF);
        step("t4_ret1",  C_RET,  0,    0, 'h91, 0, FE);
        step("t4_ret2",  C_RET,  0,    0, 'h81, 0, FE);
        step("t4_ret3",  C_RET,  0,    0, 'h71, 0, FE);
        step("t4_ret4",  C_RET,  0,    0, 'h61, 0, FE | RE);
        step("t4_ret5",  C_RET,  0,    0, 'h62, 0, FE | RE | RERR);
        step("t4_run",   C_NONE, 0,    0, 'h63, 0, FE | RE);
        // T5: interrupt entry, ignored controls in INT_WAIT, vector fetch, iret
        step("t5_br",     C_BR,                  'h40,  0,     'h40,  0,    FE | RE);
        step("t5_irq",    C_IRQ,                 0,     0,     'h0,   'h40, II | RE);
        step("t5_wait1",  C_IRQ,                 0,     0,     'h0,   'h40, II | RE);
        step("t5_wait2",  C_IRQ | C_BR | C_CALL, 'h300, 0,     'h0,   'h40, II | RE);
        step("t5_vec",    C_VV,                  0,     'h200, 'h200, 'h40, FE | RE);
        step("t5_run",    C_NONE,                0,     0,     'h201, 'h40, FE | RE);
        step("t5_iret",   C_IRET,                0,     0,     'h40,  'h40, FE | RE);
        step("t5_run2",   C_NONE,                0,     0,     'h41,  'h40, FE | RE);
        // T6: interrupt beats stall, reset aborts INT_WAIT
        step("t6_stall_irq", C_STALL | C_IRQ, 0, 0, 'h0,  'h41, II | RE);
        step("t6_rst",       C_RST,           0, 0, 'h20, 0,    FE | RE);
        step("t6_run",       C_NONE,          0, 0, 'h21, 0,    FE | RE);
        // Wrap and branch-over-call priority
        step("wrap_br",   C_BR,          'hFFFFFFFF, 0, 'hFFFFFFFF, 0, FE | RE);
        step("wrap_run",  C_NONE,        0,          0, 'h0,        0, FE | RE);
        step("br_call",   C_BR | C_CALL, 'h10,       0, 'h10,       0, FE | RE);
        step("br_call_n", C_NONE,        0,          0, 'h11,       0, FE | RE);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
